// File: rtl/fpu_result_wb.sv
// Writeback FIFO behind the FPU exception stage, with sticky IEEE status flags.
// Optional trap reporting is built when FPU_TRAP_EN is defined.
module fpu_result_wb #(
  parameter int BIT_WIDTH = 32,
  parameter int DEPTH     = 4,
  parameter int TAG_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_valid,
  input  logic [BIT_WIDTH-1:0]       i_result,
  input  logic [4:0]                 i_exception,
  input  logic [TAG_WIDTH-1:0]       i_tag,
  output logic                       o_ready,
  output logic                       o_wb_valid,
  output logic [BIT_WIDTH-1:0]       o_wb_data,
  output logic [4:0]                 o_wb_exception,
  output logic [TAG_WIDTH-1:0]       o_wb_tag,
  input  logic                       i_wb_ready,
  input  logic                       i_flag_clr,
`ifdef FPU_TRAP_EN
  input  logic [4:0]                 i_trap_mask,
  output logic                       o_trap,
  output logic [TAG_WIDTH-1:0]       o_trap_tag,
`endif
  output logic [4:0]                 o_sticky_flags,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [BIT_WIDTH-1:0] data_q [DEPTH];
  logic [4:0]           exc_q  [DEPTH];
  logic [TAG_WIDTH-1:0] tag_q  [DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [4:0]           flags_q, flags_d;
  logic                 push_s, pop_s, full_s, empty_s, trap_block_s;

`ifdef FPU_TRAP_EN
  logic                 trap_q, trap_d;
  logic [TAG_WIDTH-1:0] trap_tag_q, trap_tag_d;
  assign trap_block_s = trap_q;
  assign o_trap       = trap_q;
  assign o_trap_tag   = trap_tag_q;
`else
  assign trap_block_s = 1'b0;
`endif

  assign full_s  = (count_q == CW'(DEPTH));
  assign empty_s = (count_q == CW'(0));
  assign o_ready = !full_s && !trap_block_s;
  // A pop needs a valid head, so a push into an empty FIFO never pairs with a pop.
  assign push_s  = i_valid && o_ready;
  assign pop_s   = !empty_s && i_wb_ready;

  assign o_wb_valid     = !empty_s;
  assign o_wb_data      = empty_s ? '0 : data_q[rd_ptr_q];
  assign o_wb_exception = empty_s ? 5'b00000 : exc_q[rd_ptr_q];
  assign o_wb_tag       = empty_s ? '0 : tag_q[rd_ptr_q];
  assign o_sticky_flags = flags_q;
  assign o_count        = count_q;

  always_comb begin
    wr_ptr_d = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_s  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    if (push_s && !pop_s) begin
      count_d = count_q + CW'(1);
    end else if (pop_s && !push_s) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
    // Clear takes effect before the accepted push's exceptions are merged in.
    flags_d = i_flag_clr ? 5'b00000 : flags_q;
    if (push_s) begin
      flags_d = flags_d | i_exception;
    end else begin
      flags_d = flags_d;
    end
`ifdef FPU_TRAP_EN
    trap_d     = push_s && ((i_exception & i_trap_mask) != 5'b00000);
    trap_tag_d = trap_d ? i_tag : trap_tag_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      flags_q  <= 5'b00000;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        exc_q[i]  <= 5'b00000;
        tag_q[i]  <= '0;
      end
`ifdef FPU_TRAP_EN
      trap_q     <= 1'b0;
      trap_tag_q <= '0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      flags_q  <= flags_d;
      if (push_s) begin
        data_q[wr_ptr_q] <= i_result;
        exc_q[wr_ptr_q]  <= i_exception;
        tag_q[wr_ptr_q]  <= i_tag;
      end
`ifdef FPU_TRAP_EN
      trap_q     <= trap_d;
      trap_tag_q <= trap_tag_d;
`endif
    end
  end

endmodule

// File: tb/tb_fpu_result_wb.sv
// Directed bench for fpu_result_wb: queue-based reference model checked every cycle,
// plus hand-computed literal expectations.
module tb_fpu_result_wb;
  localparam int BW    = 32;
  localparam int DEPTH = 4;
  localparam int TW    = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic [BW-1:0] i_result = '0;
  logic [4:0]    i_exception = 5'b00000;
  logic [TW-1:0] i_tag = '0;
  logic          o_ready, o_wb_valid;
  logic [BW-1:0] o_wb_data;
  logic [4:0]    o_wb_exception;
  logic [TW-1:0] o_wb_tag;
  logic          i_wb_ready = 1'b0;
  logic          i_flag_clr = 1'b0;
  logic [4:0]    o_sticky_flags;
  logic [CW-1:0] o_count;
`ifdef FPU_TRAP_EN
  logic [4:0]    i_trap_mask = 5'b00000;
  logic          o_trap;
  logic [TW-1:0] o_trap_tag;
  logic [TW-1:0] m_trap_tag = '0;
`endif

  typedef struct packed {
    logic [BW-1:0] d;
    logic [4:0]    e;
    logic [TW-1:0] t;
  } ent_t;

  ent_t       mq[$];
  logic [4:0] m_flags = 5'b00000;
  logic       m_trap  = 1'b0;
  int         checks = 0;
  int         failures = 0;

  fpu_result_wb #(.BIT_WIDTH(BW), .DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_result(i_result),
    .i_exception(i_exception), .i_tag(i_tag), .o_ready(o_ready),
    .o_wb_valid(o_wb_valid), .o_wb_data(o_wb_data), .o_wb_exception(o_wb_exception),
    .o_wb_tag(o_wb_tag), .i_wb_ready(i_wb_ready), .i_flag_clr(i_flag_clr),
`ifdef FPU_TRAP_EN
    .i_trap_mask(i_trap_mask), .o_trap(o_trap), .o_trap_tag(o_trap_tag),
`endif
    .o_sticky_flags(o_sticky_flags), .o_count(o_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One clock of stimulus; the model advances right after the edge from its own state.
  task automatic cycle(input logic v, input logic [BW-1:0] d, input logic [4:0] e,
                       input logic [TW-1:0] t, input logic wr, input logic clr);
    bit acc, pop;
    i_valid = v; i_result = d; i_exception = e; i_tag = t;
    i_wb_ready = wr; i_flag_clr = clr;
    acc = v && (mq.size() < DEPTH) && !m_trap;
    pop = (mq.size() != 0) && wr;
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (acc) mq.push_back('{d: d, e: e, t: t});
    if (clr) m_flags = 5'b00000;
    if (acc) m_flags = m_flags | e;
`ifdef FPU_TRAP_EN
    m_trap = acc && ((e & i_trap_mask) != 5'b00000);
    if (m_trap) m_trap_tag = t;
`endif
    #1;
    i_valid = 1'b0; i_wb_ready = 1'b0; i_flag_clr = 1'b0;
  endtask

  task automatic push(input logic [TW-1:0] t, input logic [4:0] e);
    cycle(1'b1, {24'hC0FFEE, t}, e, t, 1'b0, 1'b0);
  endtask

  task automatic pop1();
    cycle(1'b0, '0, 5'b00000, '0, 1'b1, 1'b0);
  endtask

  // Continuous comparison against the model on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("count", 64'(o_count), 64'(mq.size()));
      chk("wb_valid", 64'(o_wb_valid), 64'(mq.size() != 0));
      chk("ready", 64'(o_ready), 64'((mq.size() < DEPTH) && !m_trap));
      chk("flags", 64'(o_sticky_flags), 64'(m_flags));
      if (mq.size() != 0) begin
        chk("wb_data", 64'(o_wb_data), 64'(mq[0].d));
        chk("wb_exc", 64'(o_wb_exception), 64'(mq[0].e));
        chk("wb_tag", 64'(o_wb_tag), 64'(mq[0].t));
      end else begin
        chk("wb_zero", {o_wb_data, o_wb_exception, o_wb_tag}, 64'd0);
      end
`ifdef FPU_TRAP_EN
      chk("trap", 64'(o_trap), 64'(m_trap));
      chk("trap_tag", 64'(o_trap_tag), 64'(m_trap_tag));
`endif
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_count", 64'(o_count), 64'd0);

    // Reset mid-stream with three entries queued
    push(8'd1, 5'b00011); push(8'd2, 5'b00000); push(8'd3, 5'b10000);
    chk("pre_rst_count", 64'(o_count), 64'd3);
    chk("pre_rst_flags", 64'(o_sticky_flags), 64'h13);
    rst_n = 1'b0;
    mq.delete(); m_flags = 5'b00000; m_trap = 1'b0;
    #2;
    chk("mid_rst_count", 64'(o_count), 64'd0);
    chk("mid_rst_valid", 64'(o_wb_valid), 64'd0);
    chk("mid_rst_flags", 64'(o_sticky_flags), 64'd0);
    chk("mid_rst_tag", 64'(o_wb_tag), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    chk("post_rst_ready", 64'(o_ready), 64'd1);

    // Fill past capacity; the fifth push is dropped
    for (int i = 1; i <= 5; i++) begin
      push(TW'(i), 5'b00000);
      if (i == 4) chk("full_ready", 64'(o_ready), 64'd0);
    end
    chk("full_count", 64'(o_count), 64'd4);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_tag", 64'(o_wb_tag), 64'(i));
      pop1();
    end
    chk("drained_count", 64'(o_count), 64'd0);
    chk("drained_valid", 64'(o_wb_valid), 64'd0);

    // Full with simultaneous push and pop: push refused
    for (int i = 0; i < 4; i++) push(TW'(8'h10 + i), 5'b00000);
    cycle(1'b1, 32'hDEAD0014, 5'b00000, 8'h14, 1'b1, 1'b0);
    chk("fullpop_count", 64'(o_count), 64'd3);
    chk("fullpop_head", 64'(o_wb_tag), 64'h11);
    repeat (3) pop1();

    // Push into empty with pop asserted: only the push lands
    cycle(1'b1, 32'h12345678, 5'b00000, 8'h20, 1'b1, 1'b0);
    chk("empty_pushpop_count", 64'(o_count), 64'd1);
    chk("empty_pushpop_data", 64'(o_wb_data), 64'h12345678);
    pop1();

    // Sticky flags
    cycle(1'b0, '0, 5'b00000, '0, 1'b0, 1'b1);
    chk("clr_flags", 64'(o_sticky_flags), 64'd0);
    push(8'h30, 5'b00001);
    push(8'h31, 5'b10000);
    chk("sticky_or", 64'(o_sticky_flags), 64'h11);
    cycle(1'b1, 32'h0, 5'b00010, 8'h32, 1'b1, 1'b1);
    chk("sticky_clr_push", 64'(o_sticky_flags), 64'h02);
    repeat (3) pop1();
    chk("drain_keeps_flags", 64'(o_sticky_flags), 64'h02);
    cycle(1'b0, '0, 5'b00000, '0, 1'b0, 1'b1);
    chk("clr_alone", 64'(o_sticky_flags), 64'd0);

    // Streaming: one in, one out every cycle, pointers wrap several times
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 32'hA5000000 + 32'(i), 5'b00000, TW'(8'h40 + i), 1'b1, 1'b0);
      chk("stream_count", 64'(o_count), 64'd1);
      chk("stream_tag", 64'(o_wb_tag), 64'(8'h40 + i));
    end
    pop1();
    chk("stream_end_count", 64'(o_count), 64'd0);

`ifdef FPU_TRAP_EN
    // Trap: masked exception pulses o_trap and stalls for one cycle
    i_trap_mask = 5'b00100;
    push(8'h2A, 5'b00100);
    chk("trap_hi", 64'(o_trap), 64'd1);
    chk("trap_tag_lit", 64'(o_trap_tag), 64'h2A);
    chk("trap_ready", 64'(o_ready), 64'd0);
    push(8'h2B, 5'b00000);
    chk("trap_lo", 64'(o_trap), 64'd0);
    chk("trap_drop_count", 64'(o_count), 64'd1);
    push(8'h2C, 5'b00010);
    chk("trap_unmasked", 64'(o_trap), 64'd0);
    repeat (2) pop1();
`endif

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
